// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a program image from a byte stream into instruction
//                memory and holds the processor in reset until the image is
//                complete and its XOR checksum matches.
//                Stream: header L, then 4*(L+1) big-endian data bytes, then
//                one checksum byte (XOR of L and every data byte).
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [7:0]            byteIn_i,
   input  logic                  byteValid_i,
   output logic                  byteReady_o,
   output logic [ADDR_WIDTH-1:0] imemAddress_o,
   output logic [31:0]           imemData_o,
   output logic                  imemWren_o,
   output logic                  cpuRst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEADER = 3'd1,
      S_DATA   = 3'd2,
      S_WRITE  = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;     // last word index of the image
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;     // word currently being assembled
   logic [1:0]            cnt_q, cnt_d;     // bytes already in the current word
   logic [31:0]           word_q, word_d;   // assembly shift register
   logic [7:0]            xor_q, xor_d;     // running checksum

   logic w_ready;
   logic w_xfer;
   logic w_hdr_bad;

   // Ready is a pure state decode so no input reaches an output combinationally.
   assign w_ready   = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
   assign w_xfer    = w_ready && byteValid_i;
   // A header is out of range when it has any bit at or above ADDR_WIDTH.
   assign w_hdr_bad = ((byteIn_i >> ADDR_WIDTH) != 8'd0);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= 2'd0;
         word_q  <= 32'd0;
         xor_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         xor_q   <= xor_d;
      end
   end

   // Next-state and datapath update for the load sequence.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      xor_d   = xor_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_d = S_HEADER;
               idx_d   = '0;
               cnt_d   = 2'd0;
               xor_d   = 8'd0;
            end
         end

         S_HEADER: begin
            if (w_xfer) begin
               if (w_hdr_bad) begin
                  state_d = S_ERROR;
               end else begin
                  len_d   = ADDR_WIDTH'(byteIn_i);
                  xor_d   = xor_q ^ byteIn_i;
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (w_xfer) begin
               word_d = {word_q[23:0], byteIn_i};
               xor_d  = xor_q ^ byteIn_i;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            // The write itself is a decode of this state; here we only advance.
            if (idx_q == len_q) begin
               state_d = S_CHECK;
            end else begin
               idx_d   = idx_q + ADDR_WIDTH'(1);
               cnt_d   = 2'd0;
               state_d = S_DATA;
            end
         end

         S_CHECK: begin
            if (w_xfer) begin
               state_d = (byteIn_i == xor_q) ? S_DONE : S_ERROR;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from state and registers only.
   always_comb begin
      byteReady_o   = w_ready;
      imemAddress_o = idx_q;
      imemData_o    = word_q;
      imemWren_o    = (state_q == S_WRITE);
      cpuRst_o      = (state_q != S_DONE);
      busy_o        = (state_q == S_HEADER) || (state_q == S_DATA) ||
                      (state_q == S_WRITE)  || (state_q == S_CHECK);
      done_o        = (state_q == S_DONE);
      error_o       = (state_q == S_ERROR);
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader (ADDR_WIDTH = 4).
//                Expected writes and checksums come from a simple image
//                model; observed writes are collected by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    byteIn;
   logic          byteValid;
   logic          byteReady;
   logic [AW-1:0] imemAddress;
   logic [31:0]   imemData;
   logic          imemWren;
   logic          cpuRst;
   logic          busy;
   logic          done;
   logic          error;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .byteIn_i      (byteIn),
      .byteValid_i   (byteValid),
      .byteReady_o   (byteReady),
      .imemAddress_o (imemAddress),
      .imemData_o    (imemData),
      .imemWren_o    (imemWren),
      .cpuRst_o      (cpuRst),
      .busy_o        (busy),
      .done_o        (done),
      .error_o       (error)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   logic [31:0]   img [16];     // image words of the current load
   logic [7:0]    txq [$];      // bytes to transmit
   logic [AW-1:0] wr_addr [$];  // observed write addresses
   logic [31:0]   wr_data [$];  // observed write data

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Monitor: capture every write pulse; the loader must not accept bytes then.
   always @(negedge clk) begin
      if (imemWren) begin
         wr_addr.push_back(imemAddress);
         wr_data.push_back(imemData);
         check("ready_low_in_write", {63'd0, byteReady}, 64'd0);
      end
   end

   // Checksum from the stream rule: XOR of L and every data byte.
   function automatic logic [7:0] ref_chk(input int L);
      logic [7:0] x;
      x = 8'(L);
      for (int k = 0; k <= L; k++)
         for (int b = 0; b < 4; b++)
            x ^= img[k][31-8*b -: 8];
      return x;
   endfunction

   task automatic build_image(input int L, input logic [7:0] xmask);
      txq.delete();
      txq.push_back(8'(L));
      for (int k = 0; k <= L; k++)
         for (int b = 0; b < 4; b++)
            txq.push_back(img[k][31-8*b -: 8]);
      txq.push_back(ref_chk(L) ^ xmask);
   endtask

   // Send txq; gaps randomizes byteValid, poke asserts start randomly while busy.
   task automatic send_bytes(input bit gaps, input bit poke);
      foreach (txq[i]) begin
         bit got;
         bit xfer;
         got = 1'b0;
         for (int g = 0; g < 1000 && !got; g++) begin
            byteValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byteIn    = byteValid ? txq[i] : 8'($urandom);
            if (poke) start = 1'($urandom_range(0, 1));
            xfer = byteValid && byteReady;
            @(posedge clk); #1;
            start = 1'b0;
            got   = xfer;
         end
         if (!got) begin
            check("byte_timeout", 64'd0, 64'd1);
            byteValid = 1'b0;
            return;
         end
      end
      byteValid = 1'b0;
   endtask

   task automatic pulse_start(output int s);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s = cyc;
   endtask

   task automatic check_writes(input string tag, input int L);
      check({tag, "_nwr"}, 64'(wr_data.size()), 64'(L + 1));
      for (int k = 0; k <= L; k++) begin
         if (k < wr_data.size()) begin
            check({tag, "_addr"}, 64'(wr_addr[k]), 64'(k));
            check({tag, "_data"}, 64'(wr_data[k]), 64'(img[k]));
         end
      end
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctl"}, 64'({byteReady, imemWren, cpuRst, busy, done, error}), 64'(6'b001000));
      check({tag, "_addr"}, 64'(imemAddress), 64'd0);
      check({tag, "_data"}, 64'(imemData), 64'd0);
   endtask

   initial begin
      int s;
      rst = 1'b1; start = 1'b0; byteValid = 1'b0; byteIn = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Three-word load with the exact-latency check.
      img[0] = 32'h20010005; img[1] = 32'h20020003; img[2] = 32'h00221820;
      pulse_start(s);
      check("start_hdr", 64'({byteReady, busy, cpuRst}), 64'(3'b111));
      build_image(2, 8'h00);
      send_bytes(1'b0, 1'b0);
      check("t1_latency", 64'(cyc - s + 1), 64'(2 + 5 * 3 + 1));
      check("t1_status", 64'({done, error, cpuRst}), 64'(3'b100));
      check_writes("t1", 2);

      // Same image with a corrupted checksum.
      pulse_start(s);
      build_image(2, 8'h01);
      send_bytes(1'b0, 1'b0);
      check("t2_status", 64'({done, error, cpuRst, busy}), 64'(4'b0110));
      check_writes("t2", 2);

      // Header one beyond capacity.
      pulse_start(s);
      txq.delete();
      txq.push_back(8'd16);
      send_bytes(1'b0, 1'b0);
      check("t3_status", 64'({error, busy, cpuRst, imemWren}), 64'(4'b1010));
      repeat (3) @(posedge clk);
      #1;
      check("t3_nwr", 64'(wr_data.size()), 64'd0);

      // Full capacity: 16 words, no wrap.
      for (int k = 0; k < 16; k++) img[k] = $urandom;
      pulse_start(s);
      build_image(15, 8'h00);
      send_bytes(1'b0, 1'b0);
      check("t3b_status", 64'({done, error, cpuRst}), 64'(3'b100));
      check_writes("t3b", 15);

      // Random byteValid gaps, random start pokes while busy.
      for (int k = 0; k < 2; k++) img[k] = $urandom;
      pulse_start(s);
      build_image(1, 8'h00);
      send_bytes(1'b1, 1'b1);
      check("t4_status", 64'({done, error, cpuRst}), 64'(3'b100));
      check_writes("t4", 1);

      // Reset after the 6th data byte, then a clean load.
      for (int k = 0; k < 3; k++) img[k] = $urandom;
      pulse_start(s);
      build_image(2, 8'h00);
      txq = txq[0:6];
      send_bytes(1'b0, 1'b0);
      check("t5_busy", 64'({busy, byteReady}), 64'(2'b11));
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset("t5_midrst");
      rst = 1'b0;
      check("t5_partial_nwr", 64'(wr_data.size()), 64'd1);
      wr_addr.delete();
      wr_data.delete();
      pulse_start(s);
      build_image(2, 8'h00);
      send_bytes(1'b0, 1'b1);
      check("t5_status", 64'({done, error, cpuRst}), 64'(3'b100));
      check_writes("t5", 2);

      // Reload from DONE with a single all-ones word.
      pulse_start(s);
      check("t6_restart", 64'({cpuRst, busy, done}), 64'(3'b110));
      img[0] = 32'hFFFFFFFF;
      build_image(0, 8'h00);
      check("t6_chkbyte", 64'(txq[5]), 64'h00);
      send_bytes(1'b0, 1'b0);
      check("t6_status", 64'({done, error, cpuRst}), 64'(3'b100));
      check_writes("t6", 0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
